// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive front ends.
//   - parity encodings of the cr_p control field
//   - default frame sizes (bit periods following the start bit)
//   - transmit FSM state type
//   - baud reload helper: bit length in cycles -> down-counter start value
package uart_pkg;

    localparam int unsigned CLK_DIV_W = 16;
    localparam int unsigned DATA_W    = 8;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_EVEN = 2'b10;

    // 7 data + 1 stop, and 8 data + parity + 2 stop
    localparam int unsigned MIN_FRAME_SIZE = 8;
    localparam int unsigned MAX_FRAME_SIZE = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // A divider of 0 or 1 still yields a one-cycle bit.
    function automatic logic [CLK_DIV_W-1:0] baud_reload(input logic [CLK_DIV_W-1:0] div);
        return (div <= CLK_DIV_W'(1)) ? '0 : div - CLK_DIV_W'(1);
    endfunction

endpackage

// File: rtl/tx_frontend_if.sv
// tx_frontend_if: word handshake between the TX FIFO/register logic and the
// transmit front end.
//   data        : word to send (bit7 ignored for 7-bit frames)
//   input_valid : data is valid
//   input_ready : front end can take a word this cycle
// master = word producer, slave = tx_frontend.
interface tx_frontend_if;

    logic [7:0] data;
    logic       input_valid;
    logic       input_ready;

    modport master (
        output data,
        output input_valid,
        input  input_ready
    );

    modport slave (
        input  data,
        input  input_valid,
        output input_ready
    );

endinterface

// File: rtl/tx_frontend_baud_counter.sv
// baud_counter: loadable down-counter that paces one bit period. Shared by
// the transmit and receive front ends.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : load load_val_i this cycle (takes priority over counting)
//   load_val_i   : start value, i.e. cycles-per-bit minus one
//   done_o       : counter is at zero (final cycle of the current bit)
module baud_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    // Count down to zero and hold there until the next load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/tx_frontend.sv
// tx_frontend: UART serial transmitter. Takes one word per valid/ready
// handshake and shifts it out LSB first: start bit, 7/8 data bits, optional
// parity, 1 or 2 stop bits. Data and control fields are captured at the
// handshake edge and held for the frame.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   in_if (slave)   : data / input_valid / input_ready word handshake
//   cr_clk_div_i    : clock cycles per bit period
//   cr_ds_i         : 0 = 7 data bits, 1 = 8 data bits
//   cr_p_i          : 00 none, 01 odd, 10 even (11 behaves as odd)
//   cr_s_i          : 0 = one stop bit, 1 = two stop bits
//   cr_brk_i        : line break request (only with WBUART_TX_BREAK_EN)
//   uart_tx_o       : serial line, idles high
//   busy_o          : frame in progress
// Build option: define WBUART_TX_BREAK_EN to add cr_brk_i and the break logic.
module tx_frontend #(
    parameter int unsigned MIN_FRAME_SIZE = uart_pkg::MIN_FRAME_SIZE,
    parameter int unsigned MAX_FRAME_SIZE = uart_pkg::MAX_FRAME_SIZE
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    tx_frontend_if.slave                   in_if,
    input  logic [uart_pkg::CLK_DIV_W-1:0] cr_clk_div_i,
    input  logic                           cr_ds_i,
    input  logic [1:0]                     cr_p_i,
    input  logic                           cr_s_i,
`ifdef WBUART_TX_BREAK_EN
    input  logic                           cr_brk_i,
`endif
    output logic                           uart_tx_o,
    output logic                           busy_o
);

    import uart_pkg::*;

    // One ring position per bit period, start bit included.
    localparam int unsigned RING_W = MAX_FRAME_SIZE + 1;
    localparam int unsigned IDX_W  = $clog2(RING_W);

    tx_state_t              state_q;
    logic [DATA_W-1:0]      sh_q;
    logic                   par_q;
    logic                   tx_q;
    logic [RING_W-1:0]      ring_q;
    logic                   ds_q;
    logic                   par_en_q;
    logic                   s_q;
    logic [CLK_DIV_W-1:0]   div_q;

    logic                   cnt_done_c;
    logic                   bit_end_c;
    logic                   last_data_c;
    logic                   last_stop_c;
    logic                   ready_c;
    logic                   xfer_c;
    logic                   cnt_load_c;
    logic [CLK_DIV_W-1:0]   cnt_load_val_c;
    logic [IDX_W-1:0]       last_data_idx_c;
    logic [IDX_W-1:0]       last_stop_idx_c;

    // Ring positions of the last data bit and the last stop bit for the latched frame shape.
    assign last_data_idx_c = IDX_W'(MIN_FRAME_SIZE - 1) + IDX_W'(ds_q);
    assign last_stop_idx_c = IDX_W'(MIN_FRAME_SIZE) + IDX_W'(ds_q) + IDX_W'(par_en_q) + IDX_W'(s_q);
    assign last_data_c     = ring_q[last_data_idx_c];
    assign last_stop_c     = ring_q[last_stop_idx_c];

    assign bit_end_c = cnt_done_c & (state_q != ST_IDLE);

    // Ready in IDLE, or in the very last cycle of the last stop bit so frames can abut.
`ifdef WBUART_TX_BREAK_EN
    assign ready_c = ((state_q == ST_IDLE) & ~cr_brk_i)
                   | ((state_q == ST_STOP) & cnt_done_c & last_stop_c);
`else
    assign ready_c = (state_q == ST_IDLE)
                   | ((state_q == ST_STOP) & cnt_done_c & last_stop_c);
`endif

    assign in_if.input_ready = ready_c;
    assign xfer_c            = in_if.input_valid & ready_c;

    // Reload at every bit boundary; a frame ending into IDLE leaves the counter parked at zero.
    assign cnt_load_c     = xfer_c | (bit_end_c & ~((state_q == ST_STOP) & last_stop_c));
    assign cnt_load_val_c = xfer_c ? baud_reload(cr_clk_div_i) : baud_reload(div_q);

    baud_counter #(
        .W (CLK_DIV_W)
    ) u_baud (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load_c),
        .load_val_i (cnt_load_val_c),
        .done_o     (cnt_done_c)
    );

    // Frame sequencer; tx_q always holds the level of the bit currently on the line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            sh_q     <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            ring_q   <= '0;
            ds_q     <= 1'b0;
            par_en_q <= 1'b0;
            s_q      <= 1'b0;
            div_q    <= '0;
        end else if (xfer_c) begin
            // New word: capture everything the frame needs and put out the start bit.
            state_q  <= ST_START;
            sh_q     <= {in_if.data[7] & cr_ds_i, in_if.data[6:0]};
            par_q    <= cr_p_i[0];
            tx_q     <= 1'b0;
            ring_q   <= RING_W'(1);
            ds_q     <= cr_ds_i;
            par_en_q <= (cr_p_i != PARITY_NONE);
            s_q      <= cr_s_i;
            div_q    <= cr_clk_div_i;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                end
                ST_START: begin
                    if (bit_end_c) begin
                        state_q <= ST_DATA;
                        tx_q    <= sh_q[0];
                        ring_q  <= {ring_q[RING_W-2:0], 1'b0};
                    end
                end
                ST_DATA: begin
                    if (bit_end_c) begin
                        ring_q <= {ring_q[RING_W-2:0], 1'b0};
                        par_q  <= par_q ^ sh_q[0];
                        sh_q   <= sh_q >> 1;
                        if (last_data_c) begin
                            if (par_en_q) begin
                                state_q <= ST_PARITY;
                                // Parity must include the bit that is just finishing.
                                tx_q    <= par_q ^ sh_q[0];
                            end else begin
                                state_q <= ST_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            tx_q <= sh_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end_c) begin
                        state_q <= ST_STOP;
                        tx_q    <= 1'b1;
                        ring_q  <= {ring_q[RING_W-2:0], 1'b0};
                    end
                end
                ST_STOP: begin
                    if (bit_end_c) begin
                        if (last_stop_c) begin
                            state_q <= ST_IDLE;
                            ring_q  <= '0;
                        end else begin
                            ring_q  <= {ring_q[RING_W-2:0], 1'b0};
                        end
                        tx_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    ring_q  <= '0;
                end
            endcase
        end
    end

    assign busy_o = (state_q != ST_IDLE);

`ifdef WBUART_TX_BREAK_EN
    logic brk_q;

    // Break masks the line without disturbing frame timing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            brk_q <= 1'b0;
        end else begin
            brk_q <= cr_brk_i;
        end
    end

    assign uart_tx_o = tx_q & ~brk_q;
`else
    assign uart_tx_o = tx_q;
`endif

endmodule

// File: tb/tb_tx_frontend.sv
// tb_tx_frontend: directed and randomized frames for tx_frontend, checked
// cycle by cycle against a frame model built from the serial frame rules
// (start, LSB-first data, parity, stop bits, each lasting div cycles).
module tb_tx_frontend;

    import uart_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] cr_clk_div;
    logic        cr_ds;
    logic [1:0]  cr_p;
    logic        cr_s;
    logic        cr_brk;
    logic        uart_tx;
    logic        busy;

    int n_checks;
    int n_fail;

    logic exp_tx[$];
    logic exp_rdy[$];

    tx_frontend_if in_if ();

    tx_frontend dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_if        (in_if),
        .cr_clk_div_i (cr_clk_div),
        .cr_ds_i      (cr_ds),
        .cr_p_i       (cr_p),
        .cr_s_i       (cr_s),
`ifdef WBUART_TX_BREAK_EN
        .cr_brk_i     (cr_brk),
`endif
        .uart_tx_o    (uart_tx),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check1(input string tag, input logic obs, input logic exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference frame: list of bit levels, each stretched to div cycles; ready only in the last cycle.
    task automatic add_frame(input logic [7:0] d, input int div, input logic ds,
                             input logic [1:0] p, input logic s);
        logic bits[$];
        int   per;
        int   nd;
        logic par;
        per = (div <= 1) ? 1 : div;
        nd  = ds ? 8 : 7;
        par = p[0];
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            bits.push_back(d[i]);
            par = par ^ d[i];
        end
        if (p != PARITY_NONE) bits.push_back(par);
        bits.push_back(1'b1);
        if (s) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int k = 0; k < per; k++) begin
                exp_tx.push_back(bits[i]);
                exp_rdy.push_back(1'b0);
            end
        end
        exp_rdy[exp_rdy.size() - 1] = 1'b1;
    endtask

    task automatic begin_frame(input logic [7:0] d, input int div, input logic ds,
                               input logic [1:0] p, input logic s);
        @(negedge clk);
        check1("ready_idle", in_if.input_ready, 1'b1);
        check1("busy_idle", busy, 1'b0);
        in_if.data        = d;
        in_if.input_valid = 1'b1;
        cr_clk_div        = 16'(div);
        cr_ds             = ds;
        cr_p              = p;
        cr_s              = s;
    endtask

    task automatic check_stream(input int drop_at, input bit perturb, input logic [7:0] data_at0,
                                output int busy_cnt, output int rdy_low);
        busy_cnt = 0;
        rdy_low  = 0;
        for (int c = 0; c < exp_tx.size(); c++) begin
            @(negedge clk);
            if (c == 0) in_if.data = data_at0;
            if (c == drop_at) in_if.input_valid = 1'b0;
            if (c == 0 && perturb) begin
                cr_clk_div = 16'd8;
                cr_ds      = 1'($urandom);
                cr_p       = 2'($urandom);
                cr_s       = 1'($urandom);
            end
            check1($sformatf("tx[%0d]", c), uart_tx, exp_tx[c]);
            check1($sformatf("ready[%0d]", c), in_if.input_ready, exp_rdy[c]);
            check1($sformatf("busy[%0d]", c), busy, 1'b1);
            busy_cnt += busy ? 1 : 0;
            rdy_low  += in_if.input_ready ? 0 : 1;
        end
        @(negedge clk);
        check1("tx_after", uart_tx, 1'b1);
        check1("busy_after", busy, 1'b0);
        check1("ready_after", in_if.input_ready, 1'b1);
    endtask

    task automatic run_frame(input logic [7:0] d, input int div, input logic ds,
                             input logic [1:0] p, input logic s, input bit perturb,
                             output int busy_cnt, output int rdy_low);
        exp_tx.delete();
        exp_rdy.delete();
        add_frame(d, div, ds, p, s);
        begin_frame(d, div, ds, p, s);
        check_stream(0, perturb, d, busy_cnt, rdy_low);
    endtask

    initial begin
        int bc;
        int rl;
        int len1;
        n_checks          = 0;
        n_fail            = 0;
        rst               = 1'b1;
        in_if.data        = 8'h00;
        in_if.input_valid = 1'b0;
        cr_clk_div        = 16'd4;
        cr_ds             = 1'b1;
        cr_p              = PARITY_NONE;
        cr_s              = 1'b0;
        cr_brk            = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check1("rst_tx", uart_tx, 1'b1);
        check1("rst_ready", in_if.input_ready, 1'b1);
        check1("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check1("post_rst_tx", uart_tx, 1'b1);

        // 8N1, div 4, 0xA5
        run_frame(8'hA5, 4, 1'b1, PARITY_NONE, 1'b0, 1'b0, bc, rl);
        check_int("8n1_ready_low", rl, 39);
        check_int("8n1_len", bc, 40);

        // Odd and even parity
        run_frame(8'hA5, 4, 1'b1, PARITY_ODD, 1'b0, 1'b0, bc, rl);
        check_int("odd_len", bc, 44);
        check1("odd_parity_bit", exp_tx[36], 1'b1);
        run_frame(8'hA5, 4, 1'b1, PARITY_EVEN, 1'b0, 1'b0, bc, rl);
        check_int("even_len", bc, 44);

        // 7 data bits, two stop bits; bit7 of 0xFF must not be sent
        run_frame(8'hFF, 3, 1'b0, PARITY_NONE, 1'b1, 1'b0, bc, rl);
        check_int("7n2_len", bc, 30);

        // Back-to-back: valid held high, no idle gap between frames
        exp_tx.delete();
        exp_rdy.delete();
        add_frame(8'h01, 2, 1'b1, PARITY_NONE, 1'b0);
        len1 = exp_tx.size();
        add_frame(8'h80, 2, 1'b1, PARITY_NONE, 1'b0);
        begin_frame(8'h01, 2, 1'b1, PARITY_NONE, 1'b0);
        check_stream(len1, 1'b0, 8'h80, bc, rl);
        check_int("b2b_len", bc, 40);

        // Reset in the middle of the data bits
        begin_frame(8'hF0, 4, 1'b1, PARITY_NONE, 1'b0);
        @(negedge clk);
        in_if.input_valid = 1'b0;
        repeat (12) @(negedge clk);
        check1("pre_rst_busy", busy, 1'b1);
        check1("pre_rst_tx", uart_tx, 1'b0);
        rst = 1'b1;
        #1;
        check1("midrst_tx", uart_tx, 1'b1);
        check1("midrst_ready", in_if.input_ready, 1'b1);
        check1("midrst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check1("rel_tx", uart_tx, 1'b1);
        check1("rel_busy", busy, 1'b0);
        run_frame(8'h5A, 4, 1'b1, PARITY_EVEN, 1'b0, 1'b0, bc, rl);
        check_int("after_rst_len", bc, 44);

        // Divider changed mid-frame: current frame keeps 4, next uses 8
        run_frame(8'h3C, 4, 1'b1, PARITY_NONE, 1'b0, 1'b1, bc, rl);
        check_int("div4_len", bc, 40);
        run_frame(8'h3C, 8, 1'b1, PARITY_NONE, 1'b0, 1'b0, bc, rl);
        check_int("div8_len", bc, 80);

        // Degenerate dividers give one-cycle bits
        run_frame(8'h96, 0, 1'b1, PARITY_ODD, 1'b1, 1'b0, bc, rl);
        check_int("div0_len", bc, 12);
        run_frame(8'h69, 1, 1'b0, PARITY_EVEN, 1'b0, 1'b0, bc, rl);
        check_int("div1_len", bc, 10);

        // Randomized frames, config perturbed mid-frame at random
        for (int n = 0; n < 24; n++) begin
            run_frame(8'($urandom), int'($urandom_range(0, 5)), 1'($urandom), 2'($urandom),
                      1'($urandom), 1'($urandom), bc, rl);
            check_int($sformatf("rnd%0d_ready_low", n), rl, bc - 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_frontend.md
# tx_frontend

Serial transmit front end of the UART: accepts one data word per handshake, serialises it LSB-first with start bit, optional parity and 1 or 2 stop bits onto the TX line at the configured baud. It is the transmit counterpart of the receive front end, sits between the TX FIFO/register logic and the `uart_tx_o` pad, and uses the same control-register fields.

## Interface
- `MIN_FRAME_SIZE`, default 8. Bit periods after the start bit for the smallest frame: 7 data + 1 stop.
- `MAX_FRAME_SIZE`, default 11. Bit periods after the start bit for the largest frame: 8 data + parity + 2 stop.
- `clk_i`  in  1  Clock; the only clock.
- `rst_i`  in  1  Asynchronous, active-high reset.
- `cr_clk_div_i`  in  16  Clock cycles per bit period.
- `cr_ds_i`  in  1  Data size: 0 = 7 bits, 1 = 8 bits.
- `cr_p_i`  in  2  Parity: 00 none, 01 odd, 10 even; bit0 seeds the parity accumulator.
- `cr_s_i`  in  1  Stop bits: 0 = 1, 1 = 2.
- `data_i`  in  8  Word to send; bit7 ignored when `cr_ds_i`=0.
- `input_valid_i`  in  1  `data_i` is valid.
- `input_ready_o`  out  1  Block can accept a word this cycle.
- `uart_tx_o`  out  1  Serial line; idles high.
- `busy_o`  out  1  A frame is in progress.

## Operation
- Transfer occurs when `input_valid_i` and `input_ready_o` are both high at a rising edge. `data_i`, `cr_*` and `cr_clk_div_i` are latched at that edge and held for the whole frame. Mid-frame config changes have no effect.
- Frame order: start (0), data LSB first (7/8 bits), parity if `cr_p_i`≠00, stop (1) ×1 or ×2.
- Parity = `cr_p_i[0]` XOR all transmitted data bits. 01 gives odd parity and 10 gives even parity. 11 behaves as odd.
- FSM states:
  - IDLE -> START on transfer.
  - START -> DATA after 1 period.
  - DATA -> PARITY after 7/8 periods if parity is enabled, otherwise -> STOP.
  - PARITY -> STOP after 1 period.
  - STOP -> IDLE after 1/2 periods, or -> START directly if a new transfer occurs in the final STOP cycle.
- Baud counter: loaded with `cr_clk_div_i`-1 at each bit start and decrements to 0. The bit ends when the counter equals 0. `cr_clk_div_i` of 0 or 1 gives 1-cycle bits.
- Bit counting uses a one-hot ring counter of width `MAX_FRAME_SIZE`+1, as on the receive side.
- `input_ready_o` = (state is IDLE) OR (state is STOP AND counter is 0 AND this is the last stop bit). It is combinational from registered state.
- `busy_o` = state is not IDLE.
- Reset, including mid-frame, returns immediately to IDLE with:
  - `uart_tx_o`=1
  - `input_ready_o`=1
  - `busy_o`=0
  - all counters and shift register cleared
  - the interrupted frame is dropped.

## Timing
- `uart_tx_o` is driven from a flop; no combinational path from inputs to the pad.
- The start bit appears on `uart_tx_o` in the cycle after the transfer edge.
- Each bit lasts exactly `cr_clk_div_i` cycles. The frame lasts (1 + 7/8 + 0/1 + 1/2) × div cycles, i.e. 9–12 periods.
- Back-to-back transfers produce zero idle gap between the last stop bit and the next start bit.
- `input_ready_o` is low from the cycle after a transfer until the final cycle of the last stop bit.

## Configuration
- `WBUART_TX_BREAK_EN`: when defined, adds input `cr_brk_i` (1 bit).
  - While `cr_brk_i`=1, `uart_tx_o` is forced low one cycle after assertion.
  - An in-progress frame keeps its timing but its line output is masked.
  - `input_ready_o` is held low while `cr_brk_i`=1 and the FSM is IDLE.
  - The line returns high one cycle after deassertion.
- When undefined: no `cr_brk_i` port and no break logic; the line is driven solely by the FSM.

## Structure
- Shared package `uart_pkg`:
  - parity encoding constants (`PARITY_NONE`=2'b00, `PARITY_ODD`=2'b01, `PARITY_EVEN`=2'b10)
  - `MIN_FRAME_SIZE`/`MAX_FRAME_SIZE` defaults
  - TX FSM state enum `tx_state_t`.
- One natural sub-module: `baud_counter`, a loadable 16-bit down-counter with a `done` flag. It is reusable by the receive side.

## Test plan
- div=4, ds=1, p=00, s=0, data 0xA5 -> line: 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. `input_ready_o` low for 39 cycles after the transfer.
- div=4, ds=1, data 0xA5: p=01 -> parity bit 1; p=10 -> parity bit 0. Frame is 11 periods (44 cycles).
- div=3, ds=0, p=00, s=1, data 0xFF -> 7 data bits of 1, then 2 stop periods. Bit7 is not sent. Frame is 30 cycles.
- `input_valid_i` held high with 0x01 then 0x80, div=2 -> second start bit immediately follows the first frame's stop bit, with no extra high cycle.
- Assert `rst_i` mid-DATA, then release -> `uart_tx_o`=1, `input_ready_o`=1 and `busy_o`=0 immediately. The next transfer sends a clean frame.
- Change `cr_clk_div_i` 4 -> 8 mid-frame -> current frame keeps 4-cycle bits; the next frame uses 8-cycle bits.
